// File: rtl/nav_pkg.sv
// Shared types and defaults for the navigation controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nav_pkg;

  // FSM state encodings; also exported on state_dbg
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_R = 3'd2,
    ST_TURN_L = 3'd3,
    ST_SETTLE = 3'd4
  } nav_state_t;

  // Last turn direction
  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } nav_dir_t;

  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_TURN_CYCLES   = 16;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_TIMER_W       = 8;

endpackage

// File: rtl/nav_controller_if.sv
// Run switch, obstacle sensors and motion command bundle of the navigation controller.
// Latency: n/a (wiring only).
// Backpressure: none; commands are level signals consumed every cycle.
interface nav_controller_if;
  logic       enable;
  logic       obs_front;
  logic       obs_left;
  logic       obs_right;
  logic       Frente;
  logic       RotR;
  logic       RotL;
  logic [2:0] state_dbg;

  // Stimulus / system side
  modport master (
    output enable, obs_front, obs_left, obs_right,
    input  Frente, RotR, RotL, state_dbg
  );

  // Controller side
  modport slave (
    input  enable, obs_front, obs_left, obs_right,
    output Frente, RotR, RotL, state_dbg
  );
endinterface

// File: rtl/sensor_debounce.sv
// Synchronizes one asynchronous sensor and filters out changes shorter than DEB_CYCLES.
// Latency: 2 sync edges + DEB_CYCLES edges from a stable raw change to filt.
// Backpressure: none; free-running per-cycle filter.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMER_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam logic [TIMER_W-1:0] DEB_LAST = TIMER_W'(DEB_CYCLES - 1);

  logic               sync1;
  logic               sync2;
  logic [TIMER_W-1:0] cnt;

  // Two-flop synchronizer for the asynchronous sensor input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreement cycles; commit the new value on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync2 != filt) begin
      if (cnt == DEB_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/nav_controller.sv
// Vacuum robot navigation: debounced obstacle sensors drive a timed forward/turn/settle FSM.
// Latency: enable->Frente 1 edge; sensor change->command DEB_CYCLES+3 edges.
// Backpressure: none; Moore one-hot-or-zero commands, enable=0 forces IDLE next edge.
module nav_controller
  import nav_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMER_W       = DEF_TIMER_W
) (
  input logic         clk,
  input logic         rst_n,
  nav_controller_if.slave nav
);

  localparam logic [TIMER_W-1:0] TURN_LOAD   = TIMER_W'(TURN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  logic front_f;
  logic left_f;
  logic right_f;

  nav_state_t         state;
  nav_state_t         state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  nav_dir_t           last_dir;
  nav_dir_t           last_dir_nxt;

  logic frente;
  logic rot_r;
  logic rot_l;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .TIMER_W(TIMER_W)) u_deb_front (
    .clk(clk), .rst_n(rst_n), .raw(nav.obs_front), .filt(front_f)
  );
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .TIMER_W(TIMER_W)) u_deb_left (
    .clk(clk), .rst_n(rst_n), .raw(nav.obs_left), .filt(left_f)
  );
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .TIMER_W(TIMER_W)) u_deb_right (
    .clk(clk), .rst_n(rst_n), .raw(nav.obs_right), .filt(right_f)
  );

  // State, timer and turn-direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      last_dir <= DIR_R;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      last_dir <= last_dir_nxt;
    end
  end

  // Next-state logic; disable overrides everything
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    last_dir_nxt = last_dir;
    if (!nav.enable) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_FWD;
        ST_FWD: begin
          if (front_f) begin
            timer_nxt = TURN_LOAD;
            // Left only when right is blocked and left is clear; otherwise prefer right
            if (right_f && !left_f) begin
              state_nxt    = ST_TURN_L;
              last_dir_nxt = DIR_L;
            end else begin
              state_nxt    = ST_TURN_R;
              last_dir_nxt = DIR_R;
            end
          end
        end
        ST_TURN_R, ST_TURN_L: begin
          if (timer == '0) begin
            state_nxt = ST_SETTLE;
            timer_nxt = SETTLE_LOAD;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            if (!front_f) begin
              state_nxt = ST_FWD;
            end else begin
              // Keep turning the same way; side sensors are deliberately ignored here
              state_nxt = (last_dir == DIR_L) ? ST_TURN_L : ST_TURN_R;
              timer_nxt = TURN_LOAD;
            end
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Moore output decode; at most one command per state
  always_comb begin
    frente = 1'b0;
    rot_r  = 1'b0;
    rot_l  = 1'b0;
    case (state)
      ST_FWD:    frente = 1'b1;
      ST_TURN_R: rot_r  = 1'b1;
      ST_TURN_L: rot_l  = 1'b1;
      default: ;
    endcase
  end

  assign nav.Frente    = frente;
  assign nav.RotR      = rot_r;
  assign nav.RotL      = rot_l;
  assign nav.state_dbg = state;

endmodule

// File: tb/tb_nav_controller.sv
// Directed self-checking bench for nav_controller with default parameters.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_nav_controller;

  // {state_dbg, Frente, RotR, RotL}
  localparam logic [5:0] E_IDLE   = 6'b000_000;
  localparam logic [5:0] E_FWD    = 6'b001_100;
  localparam logic [5:0] E_TURN_R = 6'b010_010;
  localparam logic [5:0] E_TURN_L = 6'b011_001;
  localparam logic [5:0] E_SETTLE = 6'b100_000;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  nav_controller_if nav ();

  nav_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nav   (nav)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] observed();
    return {nav.state_dbg, nav.Frente, nav.RotR, nav.RotL};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = observed();
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  // Advance n edges, checking the expected output vector after each one
  task automatic run_chk(input string tag, input logic [5:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, exp);
    end
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    nav.enable    = 1'b0;
    nav.obs_front = 1'b0;
    nav.obs_left  = 1'b0;
    nav.obs_right = 1'b0;

    // Reset state
    #2;
    chk("reset_async", E_IDLE);
    run_chk("reset_hold", E_IDLE, 3);
    rst_n = 1'b1;
    run_chk("idle_disabled", E_IDLE, 3);

    // Enable -> forward after one edge, held
    nav.enable = 1'b1;
    run_chk("fwd_entry", E_FWD, 1);
    run_chk("fwd_hold", E_FWD, 10);

    // 3-cycle front glitch is filtered out
    nav.obs_front = 1'b1;
    tick(); tick(); tick();
    nav.obs_front = 1'b0;
    run_chk("glitch_fwd", E_FWD, 15);

    // Right turn: front blocked, command changes on the 7th edge
    nav.obs_front = 1'b1;
    run_chk("rt_latency_fwd", E_FWD, 6);
    run_chk("rt_start", E_TURN_R, 1);
    nav.obs_front = 1'b0;
    run_chk("rt_hold", E_TURN_R, 15);
    run_chk("rt_settle", E_SETTLE, 2);
    run_chk("rt_back_fwd", E_FWD, 1);
    run_chk("rt_fwd_hold", E_FWD, 3);

    // Left choice: front and right blocked, left clear
    nav.obs_front = 1'b1;
    nav.obs_right = 1'b1;
    run_chk("lt_latency_fwd", E_FWD, 6);
    run_chk("lt_start", E_TURN_L, 1);
    // Right clears, but the repeat turn must follow last_dir
    nav.obs_right = 1'b0;
    run_chk("lt_hold", E_TURN_L, 15);
    run_chk("lt_settle", E_SETTLE, 2);
    run_chk("lt_repeat_start", E_TURN_L, 1);
    nav.obs_front = 1'b0;
    run_chk("lt_repeat_hold", E_TURN_L, 15);
    run_chk("lt_settle2", E_SETTLE, 2);
    run_chk("lt_back_fwd", E_FWD, 1);

    // All blocked: repeated right turns
    nav.obs_front = 1'b1;
    nav.obs_left  = 1'b1;
    nav.obs_right = 1'b1;
    run_chk("ab_latency_fwd", E_FWD, 6);
    run_chk("ab_turn1", E_TURN_R, 16);
    run_chk("ab_settle1", E_SETTLE, 2);
    run_chk("ab_turn2", E_TURN_R, 16);
    run_chk("ab_settle2", E_SETTLE, 2);
    run_chk("ab_turn3", E_TURN_R, 5);

    // Disable mid-turn -> IDLE after the next edge
    nav.enable = 1'b0;
    run_chk("disable_midturn", E_IDLE, 1);
    run_chk("disable_hold", E_IDLE, 3);

    // Re-enable with sensors still blocked, then reset mid-TURN_R
    nav.enable = 1'b1;
    run_chk("reen_fwd", E_FWD, 1);
    run_chk("reen_turn", E_TURN_R, 4);
    rst_n = 1'b0;
    #2;
    chk("reset_midturn_async", E_IDLE);
    nav.enable    = 1'b0;
    nav.obs_front = 1'b0;
    nav.obs_left  = 1'b0;
    nav.obs_right = 1'b0;
    run_chk("reset_midturn_hold", E_IDLE, 2);
    rst_n = 1'b1;
    run_chk("post_reset_idle", E_IDLE, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nav_controller.md
# nav_controller

Navigation controller for the vacuum robot. It synchronizes and debounces the three raw obstacle sensors and runs a timed drive state machine. It produces the `Frente` / `RotR` / `RotL` motion commands that feed the motor/indicator matrix stage directly downstream. At most one command is high in any cycle.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable cycles required before a debounced sensor value changes.
- `TURN_CYCLES`, default 16: number of cycles a rotation command is held.
- `SETTLE_CYCLES`, default 2: all-off cycles after each rotation.
- `TIMER_W`, default 8: width of the turn/settle timer and debounce counters. `TURN_CYCLES`, `SETTLE_CYCLES` and `DEB_CYCLES` must each be ≥1 and < 2^TIMER_W.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run switch, already synchronous to `clk`.
- `obs_front`, `obs_left`, `obs_right`  in  1 each  raw obstacle sensors, asynchronous, active-high (1 = blocked).
- `Frente`  out  1  drive forward.
- `RotR`  out  1  rotate right.
- `RotL`  out  1  rotate left.
- `state_dbg`  out  3  current FSM state encoding.

## Operation
- Sensor path, per sensor:
  - 2-flop synchronizer, then a debounce filter.
  - The filtered value takes the synchronized value once the two have differed for `DEB_CYCLES` consecutive cycles.
  - Any cycle of agreement clears the debounce counter.
- FSM states and encodings: IDLE=0, FWD=1, TURN_R=2, TURN_L=3, SETTLE=4. A `last_dir` register (0=R, 1=L) records the last turn direction.
- Outputs are a Moore decode of the state register:
  - FWD → `Frente`
  - TURN_R → `RotR`
  - TURN_L → `RotL`
  - IDLE and SETTLE → all 0
- `enable`=0 has top priority: from any state, the next state is IDLE.
- IDLE → FWD when `enable`=1.
- FWD, on filtered front=1:
  - Right clear → TURN_R.
  - Else left clear → TURN_L.
  - Else both blocked → TURN_R.
  - On any of these transitions, timer loads `TURN_CYCLES`-1 and `last_dir` is updated.
- TURN_R / TURN_L: timer decrements each cycle. At timer==0 → SETTLE, with timer loaded to `SETTLE_CYCLES`-1.
- SETTLE at timer==0:
  - Front clear → FWD.
  - Front blocked → turn again in `last_dir` direction, timer reloaded to `TURN_CYCLES`-1. Side sensors are not re-evaluated.
- Reset, including mid-turn:
  - State goes to IDLE and all outputs to 0 immediately and asynchronously.
  - Timer, debounce counters, synchronizer flops, filtered values and `last_dir` all clear to 0.

## Timing
- Reset values: `Frente`=`RotR`=`RotL`=0, `state_dbg`=0.
- `enable` rising, sampled at edge N → `Frente`=1 after edge N.
- Sensor latency: a raw change held stable reaches the filtered value after 2+`DEB_CYCLES` edges. The FSM reacts on the following edge, so total latency is `DEB_CYCLES`+3 edges.
- Pulses shorter than `DEB_CYCLES` synchronized cycles are ignored.
- Rotation commands are high for exactly `TURN_CYCLES` cycles, followed by exactly `SETTLE_CYCLES` all-zero cycles.
- Command handoffs never overlap: two commands are never high in the same cycle.

## Structure
- Package `nav_pkg` holds:
  - the state enum and its encodings;
  - default constants for `DEB_CYCLES`, `TURN_CYCLES` and `SETTLE_CYCLES`;
  - the direction encoding.
- Sub-module `sensor_debounce` contains the synchronizer, counter and filtered register. It is instantiated three times.
- The top level holds the FSM, the timer and the output decode.

## Test plan
All scenarios use default parameters.
- Reset: assert `rst_n`=0 mid-TURN_R → all outputs 0 in the same cycle. Release with `enable`=0 → stays in IDLE.
- Forward: `enable`=1 with all sensors clear → `Frente`=1 one edge later and held indefinitely.
- Right turn: in FWD, set `obs_front`=1 and hold → `Frente` falls and `RotR` rises on the 7th edge. `RotR` stays high 16 cycles, then 2 cycles of 0. If `obs_front` has been cleared meanwhile, `Frente`=1 follows.
- Left choice: front and right both blocked, left clear → `RotL` for 16 cycles.
- All blocked: front, left and right blocked → `RotR` 16, off 2, `RotR` 16, repeating while front stays blocked.
- Glitch and disable:
  - 3-cycle `obs_front` pulse in FWD → `Frente` stays 1 with no state change.
  - `enable`=0 mid-turn → IDLE and all outputs 0 after the next edge.
